seq_restoring_divider: RTL and testbench

//  - Unsigned sequential restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//  - Inverse arithmetic to the adder/subtractor chain: one trial subtraction per clock, WIDTH iterations.
//  - Sits beside the ripple adders as the lab datapath's multi-cycle arithmetic unit.
//  - Uses a start/busy/done handshake.

---
 rtl/lab_pkg.sv | 12 +
 rtl/div_trial_sub.sv | 28 ++
 rtl/full_adder.sv | 13 +
 rtl/seq_restoring_divider.sv | 138 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/lab_pkg.sv
// Shared constants for the lab datapath: FSM state encoding and default operand width.
package lab_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor: minuend + ~subtrahend + 1 on a full_adder ripple chain.
module div_trial_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (minuend[i]),
      .b  (~subtrahend[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  // A two's-complement subtract borrows exactly when the final carry is absent.
  assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder; the cell the lab's ripple adders and the divider's trial subtractor are built from.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one trial subtraction per clock, WIDTH iterations, start/busy/done handshake.
module seq_restoring_divider
  import lab_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept;
  logic             last_iter;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_msb;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
  assign last_iter  = (state_q == S_CALC) && (cnt_q == CNT_W'(WIDTH - 1));
  assign r_shift    = {r_q, q_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .minuend    (r_shift),
    .subtrahend ({1'b0, dvsr_q}),
    .diff       (trial_diff),
    .borrow     (trial_borrow)
  );

  // Partial remainder stays below divisor, so the top bit of either candidate is always zero.
  assign r_next     = trial_borrow ? r_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
  assign q_next     = {q_q[WIDTH-2:0], ~trial_borrow};
  assign unused_msb = r_shift[WIDTH] ^ trial_diff[WIDTH];

  // NOTE: every path below starts from a default, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start)                    state_d = (divisor == '0) ? S_DONE : S_CALC;
        else                          state_d = S_IDLE;
      end
      S_CALC:         if (last_iter)  state_d = S_DONE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    dvsr_d = dvsr_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    cnt_d  = cnt_q;
    if (can_accept && start) begin
      if (divisor == '0) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end else begin
        r_d    = '0;
        q_d    = dividend;
        dvsr_d = divisor;
        cnt_d  = '0;
      end
    end else if (state_q == S_CALC) begin
      r_d   = r_next;
      q_d   = q_next;
      cnt_d = cnt_q + 1'b1;
      if (last_iter) begin
        quot_d = q_next;
        rem_d  = r_next;
        dbz_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves every output at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      q_q    <= '0;
      dvsr_q <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_q    <= r_d;
      q_q    <= q_d;
      dvsr_q <= dvsr_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busy = (state_q == S_CALC);
    done = (state_q == S_DONE);
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: reset, arithmetic corners, divide-by-zero, handshake and abort.
module tb_seq_restoring_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] vec_a [4] = '{16'hFFFF, 16'hFFFF, 16'd3,  16'd0};
  logic [W-1:0] vec_b [4] = '{16'h0001, 16'hFFFF, 16'd10, 16'd5};
  logic [W-1:0] vec_q [4] = '{16'hFFFF, 16'h0001, 16'd0,  16'd0};
  logic [W-1:0] vec_r [4] = '{16'h0000, 16'h0000, 16'd3,  16'd0};

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done is seen; bounded at 40.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 16'd0) begin n_fail++; $display("FAIL reset_quotient: got %h expected 0000", quotient); end
    n_checks++; if (remainder !== 16'd0) begin n_fail++; $display("FAIL reset_remainder: got %h expected 0000", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc, bcyc;
    pulse_start(16'd100, 16'd7);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL basic_latency: got %0d expected 16", cyc); end
    n_checks++; if (bcyc != 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 16", bcyc); end
    n_checks++; if (quotient !== 16'd14) begin n_fail++; $display("FAIL basic_quotient: got %0d expected 14", quotient); end
    n_checks++; if (remainder !== 16'd2) begin n_fail++; $display("FAIL basic_remainder: got %0d expected 2", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_checks++; if (quotient !== 16'd14) begin n_fail++; $display("FAIL basic_quotient_held: got %0d expected 14", quotient); end
  endtask

  task automatic test_boundaries;
    int cyc, bcyc;
    for (int i = 0; i < 4; i++) begin
      pulse_start(vec_a[i], vec_b[i]);
      wait_done(cyc, bcyc);
      n_checks++;
      if (cyc != 16) begin
        n_fail++; $display("FAIL bound_latency[%0d]: got %0d expected 16", i, cyc);
      end
      n_checks++;
      if (quotient !== vec_q[i]) begin
        n_fail++; $display("FAIL bound_quotient[%0d]: got %h expected %h", i, quotient, vec_q[i]);
      end
      n_checks++;
      if (remainder !== vec_r[i]) begin
        n_fail++; $display("FAIL bound_remainder[%0d]: got %h expected %h", i, remainder, vec_r[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_by_zero;
    int cyc, bcyc;
    pulse_start(16'd5, 16'd0);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 0", cyc); end
    n_checks++; if (bcyc != 0) begin n_fail++; $display("FAIL dbz_busy: got %0d expected 0", bcyc); end
    n_checks++; if (quotient !== 16'hFFFF) begin n_fail++; $display("FAIL dbz_quotient: got %h expected ffff", quotient); end
    n_checks++; if (remainder !== 16'd5) begin n_fail++; $display("FAIL dbz_remainder: got %0d expected 5", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dbz_done_pulse: got %b expected 0", done); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag_held: got %b expected 1", div_by_zero); end
    pulse_start(16'd100, 16'd7);
    wait_done(cyc, bcyc);
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_cleared: got %b expected 0", div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    pulse_start(16'd1000, 16'd3);
    repeat (5) begin @(posedge clk); #1; end
    pulse_start(16'd9, 16'd9);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc + 6 != 16) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 16", cyc + 6); end
    n_checks++; if (quotient !== 16'd333) begin n_fail++; $display("FAIL busy_start_quotient: got %0d expected 333", quotient); end
    n_checks++; if (remainder !== 16'd1) begin n_fail++; $display("FAIL busy_start_remainder: got %0d expected 1", remainder); end
    pulse_start(16'd9, 16'd9);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: got %b expected 1", busy); end
    n_checks++; if (quotient !== 16'd333) begin n_fail++; $display("FAIL b2b_quotient_held: got %0d expected 333", quotient); end
    wait_done(cyc, bcyc);
    n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 16", cyc); end
    n_checks++; if (quotient !== 16'd1) begin n_fail++; $display("FAIL b2b_quotient: got %0d expected 1", quotient); end
    n_checks++; if (remainder !== 16'd0) begin n_fail++; $display("FAIL b2b_remainder: got %0d expected 0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc;
    int cyc, bcyc;
    int done_seen = 0;
    pulse_start(16'd50000, 16'd7);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (quotient !== 16'd0) begin n_fail++; $display("FAIL abort_quotient: got %0d expected 0", quotient); end
    n_checks++; if (remainder !== 16'd0) begin n_fail++; $display("FAIL abort_remainder: got %0d expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dbz: got %b expected 0", div_by_zero); end
    repeat (4) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
    end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done cycles expected 0", done_seen); end
    pulse_start(16'd50000, 16'd7);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL after_abort_latency: got %0d expected 16", cyc); end
    n_checks++; if (quotient !== 16'd7142) begin n_fail++; $display("FAIL after_abort_quotient: got %0d expected 7142", quotient); end
    n_checks++; if (remainder !== 16'd6) begin n_fail++; $display("FAIL after_abort_remainder: got %0d expected 6", remainder); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
